dmem_axi_bridge: RTL and testbench
==================================

# dmem_axi_bridge

- Responder (slave) end of the CPU data-side sram-like interface (`data_req/wr/size/addr/wdata` in; `addr_ok/data_ok/rdata` out).
- Converts each accepted request into a single-beat AXI4 read or write transaction on the master port toward the interconnect.
- Keeps at most one transaction outstanding.
- Sits between the core's MEM stage and the AXI crossbar.

## Interface
Parameters
- `AXI_ID`, default 4'd1: value driven on `arid`/`awid`; ignored on `rid`/`bid`.

Ports
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `data_req` in 1: request valid.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `data_addr` in 32: byte address.
- `data_wdata` in 32: write data, already lane-aligned by the requester.
- `data_addr_ok` out 1: request accepted when `data_req & data_addr_ok`.
- `data_data_ok` out 1: one-cycle pulse; read data valid or write complete.
- `data_rdata` out 32: read data, valid while `data_data_ok`.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI read address channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI read data channel.
- `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1: AXI write address channel.
- `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1: AXI write data channel.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1: AXI write response channel.

## Operation
- Constant outputs: `arlen = awlen = 0`, `arburst = awburst = 2'b01`, `wlast = 1`.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- **IDLE**
  - `data_addr_ok = 1`.
  - On a handshake, latch `wr`, `addr`, `size` (3 mapped to 2) and `wdata`.
  - Go to RD_A if `wr = 0`, else WR_AW.
- **RD_A**
  - `arvalid = 1`, `araddr` = latched addr, `arsize = {1'b0, size}`.
  - On `arready`, go to RD_D.
- **RD_D**
  - `rready = 1`.
  - On `rvalid`, register `rdata` into `data_rdata` and go to DONE.
  - `rresp`, `rid` and `rlast` are ignored.
- **WR_AW**
  - `awvalid` and `wvalid` both assert on entry.
  - Each valid drops independently after its own handshake; two sticky flags `aw_done` and `w_done` record completion.
  - Once both are done (including both completing in the same cycle), go to WR_B.
- **WR_B**
  - `bready = 1`.
  - On `bvalid`, go to DONE.
  - `bresp` is ignored.
- **DONE**
  - `data_data_ok = 1` for exactly one cycle; `data_addr_ok = 0`.
  - Next state is IDLE.
- `wstrb` encoding:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `addr[1] ? 4'b1100 : 4'b0011`.
  - word: `4'b1111`.
- Misaligned half/word addresses are never presented; the core traps them before MEM. No check is made here.
- `data_rdata` holds its last value outside DONE.
- `data_req` asserted outside IDLE is ignored and not queued.
- The requester holds `data_req` and its fields stable until it sees `addr_ok`.

## Timing
- Reset (asynchronous, any state): FSM returns to IDLE.
  - All AXI valid/ready outputs, `data_data_ok`, `aw_done` and `w_done` go to 0.
  - `data_rdata` and the latched fields go to 0.
  - `data_addr_ok` is 1 as soon as reset deasserts.
  - A transaction aborted by reset is dropped; the interconnect is reset with the same `resetn`.
- Read, zero-wait slave: accept at cycle 0; `arvalid` and handshake at cycle 1; `rvalid` at cycle 2; `data_data_ok` at cycle 3.
- Write, zero-wait slave: accept at cycle 0; AW and W handshakes at cycle 1; `bvalid` at cycle 2; `data_data_ok` at cycle 3.
- Next accept is no earlier than the cycle after DONE. Minimum request-to-request spacing is 4 cycles.
- AXI valids are driven only from registered state: no combinational path from `*ready` to `*valid`.
- Once `arvalid`, `awvalid` or `wvalid` asserts, it never drops before its own handshake.
- Back-pressure of any length on AR, AW, W, R or B only stretches the matching state; outputs stay stable throughout.

## Test plan
- **Word read:** `req, wr=0, size=2, addr=0x1000_0004`; slave returns `rdata=0xDEADBEEF` one cycle after AR.
  - Required: `araddr=0x1000_0004`, `arsize=2`, `data_ok` at cycle 3, `data_rdata=0xDEADBEEF`, `addr_ok=0` during cycles 1-3.
- **Byte write:** `size=0, addr=0x...3, wdata=0xAA000000`.
  - Required: `wstrb=4'b1000`, `awsize=0`, `wdata` passed unchanged, `data_ok` one cycle after the `bvalid` handshake.
- **Split AW/W handshakes:** `awready` delayed 3 cycles, `wready` immediate.
  - Required: `wvalid` drops after 1 cycle, `awvalid` holds until its handshake, `bready` only after both handshakes.
- **Back-pressure:** `rvalid` withheld 10 cycles.
  - Required: `rready` stays high, no `data_ok`, `data_req` ignored, `addr_ok=0` throughout.
- **Reset mid-operation:** assert `resetn=0` while in RD_D.
  - Required: all valids and `data_ok` are 0 immediately; after release, the next request completes normally.
- **Half-word strobes:** half write at `addr[1]=1` gives `wstrb=4'b1100`; `size=3` write gives `wstrb=4'b1111` and `awsize=2`.

Source files
------------

// File: rtl/dmem_axi_bridge_if.sv
// Single-beat AXI4 master/slave bundle used between the data-side bridge and the interconnect.
// All five channels are grouped here; the bridge takes the master modport.
interface dmem_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dmem_axi_bridge.sv
// CPU data-side sram-like responder that turns each accepted request into one
// single-beat AXI4 read or write, with at most one transaction in flight.
module dmem_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   data_req,
    input  logic                   data_wr,
    input  logic [1:0]             data_size,
    input  logic [31:0]            data_addr,
    input  logic [31:0]            data_wdata,
    output logic                   data_addr_ok,
    output logic                   data_data_ok,
    output logic [31:0]            data_rdata,
    dmem_axi_bridge_if.master      axi
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic        accept;

    // Response id/resp/last carry nothing this bridge acts on.
    logic        unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << offset;
            2'd1:    strb = offset[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    assign accept = (state == IDLE) && data_req;
    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_req) state_nxt = data_wr ? WR_AW : RD_A;
            RD_A:    if (axi.arready) state_nxt = RD_D;
            RD_D:    if (axi.rvalid) state_nxt = DONE;
            WR_AW:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
            WR_B:    if (axi.bvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Valids come from state and the registered done flags only, never from a ready.
    always_comb begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        axi.arvalid  = 1'b0;
        axi.rready   = 1'b0;
        axi.awvalid  = 1'b0;
        axi.wvalid   = 1'b0;
        axi.bready   = 1'b0;
        case (state)
            IDLE:  data_addr_ok = 1'b1;
            RD_A:  axi.arvalid  = 1'b1;
            RD_D:  axi.rready   = 1'b1;
            WR_AW: begin
                axi.awvalid = !aw_done;
                axi.wvalid  = !w_done;
            end
            WR_B:  axi.bready   = 1'b1;
            DONE:  data_data_ok = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_wr    <= 1'b0;
            req_size  <= 2'd0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
        end else if (accept) begin
            req_wr    <= data_wr;
            req_size  <= norm_size(data_size);
            req_addr  <= data_addr;
            req_wdata <= data_wdata;
        end
    end

    // Sticky completion flags let AW and W finish in either order or together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR_AW) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_rdata <= 32'd0;
        end else if ((state == RD_D) && axi.rvalid) begin
            data_rdata <= axi.rdata;
        end
    end

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = req_addr;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, req_size};
    assign axi.arburst = 2'b01;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = req_addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, req_size};
    assign axi.awburst = 2'b01;

    assign axi.wdata   = req_wdata;
    assign axi.wstrb   = lane_strb(req_size, req_addr[1:0]);
    assign axi.wlast   = 1'b1;

    // req_wr is kept for visibility of the latched request; the FSM path already encodes it.
    logic unused_req_wr;
    assign unused_req_wr = req_wr;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge: a transaction-timeline model predicts every
// output cycle by cycle, plus literal expectations for the headline scenarios.
module tb_dmem_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    always #5 clk = ~clk;

    dmem_axi_bridge_if axi();

    dmem_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (axi)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit run_chk = 1'b0;

    // Transaction timeline: absolute cycle numbers of every handshake.
    bit          s_active = 1'b0;
    bit          s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdat;
    int          s_t0, s_tar, s_tr, s_taw, s_tw, s_tb, s_tdone;
    logic [31:0] m_rdata = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
        int n;
        int base;
        logic [3:0] s;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = (int'(addr[1:0]) / n) * n;
        s    = 4'b0000;
        for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + n);
        return s;
    endfunction

    function automatic logic [2:0] model_size(input logic [1:0] size);
        return (size == 2'd3) ? 3'd2 : {1'b0, size};
    endfunction

    function automatic bit in_win(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (s_active && !s_wr && cyc == s_tdone) m_rdata = s_rdat;
        axi.arready = s_active && !s_wr && (cyc == s_tar);
        axi.rvalid  = s_active && !s_wr && (cyc == s_tr);
        axi.rdata   = axi.rvalid ? s_rdat : (32'h0BAD_0000 + 32'(cyc));
        axi.awready = s_active && s_wr && (cyc == s_taw);
        axi.wready  = s_active && s_wr && (cyc == s_tw);
        axi.bvalid  = s_active && s_wr && (cyc == s_tb);
    endtask

    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // da: address-channel delay, dw: W delay, dd: R or B delay (cycles before the slave responds).
    task automatic do_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdat,
                          input int da, input int dw, input int dd, input bit noise);
        s_wr = wr; s_size = size; s_addr = addr; s_wdata = wdata; s_rdat = rdat;
        s_t0 = cyc;
        if (!wr) begin
            s_tar = cyc + 1 + da;
            s_tr  = s_tar + 1 + dd;
            s_tdone = s_tr + 1;
            s_taw = -10; s_tw = -10; s_tb = -10;
        end else begin
            s_taw = cyc + 1 + da;
            s_tw  = cyc + 1 + dw;
            s_tb  = ((s_taw > s_tw) ? s_taw : s_tw) + 1 + dd;
            s_tdone = s_tb + 1;
            s_tar = -10; s_tr = -10;
        end
        s_active   = 1'b1;
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wdata;
        while (cyc < s_tdone) begin
            step();
            if (noise && cyc < s_tdone) begin
                data_req   = 1'b1;
                data_wr    = ~wr;
                data_size  = 2'd1;
                data_addr  = 32'hFFFF_FFFC;
                data_wdata = 32'h5555_5555;
            end else begin
                data_req = 1'b0;
            end
        end
        step();
        data_req = 1'b0;
    endtask

    // Every-cycle comparison against the timeline model.
    always @(negedge clk) begin
        if (run_chk) begin
            int c;
            bit ex_ar, ex_r, ex_aw, ex_w, ex_b, ex_ok, ex_aok;
            int mx;
            c = cyc;
            ex_ar = 1'b0; ex_r = 1'b0; ex_aw = 1'b0; ex_w = 1'b0; ex_b = 1'b0;
            if (s_active && !s_wr) begin
                ex_ar = in_win(c, s_t0 + 1, s_tar);
                ex_r  = in_win(c, s_tar + 1, s_tr);
            end
            if (s_active && s_wr) begin
                mx    = (s_taw > s_tw) ? s_taw : s_tw;
                ex_aw = in_win(c, s_t0 + 1, s_taw);
                ex_w  = in_win(c, s_t0 + 1, s_tw);
                ex_b  = in_win(c, mx + 1, s_tb);
            end
            ex_ok  = s_active && (c == s_tdone);
            ex_aok = !(s_active && c > s_t0 && c <= s_tdone);
            check("ctrl", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, data_data_ok},
                  {ex_ar, ex_r, ex_aw, ex_w, ex_b, ex_ok});
            if (resetn) check("addr_ok", data_addr_ok, ex_aok);
            check("rdata", data_rdata, m_rdata);
            check("consts", {axi.arid, axi.awid, axi.arlen, axi.awlen, axi.arburst, axi.awburst, axi.wlast},
                  {4'd1, 4'd1, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1});
            if (ex_ar) check("ar_fields", {axi.araddr, axi.arsize}, {s_addr, model_size(s_size)});
            if (ex_aw) check("aw_fields", {axi.awaddr, axi.awsize}, {s_addr, model_size(s_size)});
            if (ex_w)  check("w_fields", {axi.wdata, axi.wstrb}, {s_wdata, model_strb(s_size, s_addr)});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        resetn = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.rid = 4'hE; axi.rresp = 2'b10; axi.rlast = 1'b0;
        axi.bid = 4'hD; axi.bresp = 2'b11;
        repeat (3) step();
        check("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, data_data_ok}, 6'd0);
        check("rst_rdata", data_rdata, 32'd0);
        resetn = 1'b1;
        #1;
        check("rst_addr_ok", data_addr_ok, 1'b1);
        run_chk = 1'b1;
        step();

        // Word read, zero-wait slave
        b = cyc;
        fork
            do_txn(1'b0, 2'd2, 32'h1000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
            begin
                at_neg(b + 1);
                check("rd_lit_ar", {axi.arvalid, axi.araddr, axi.arsize}, {1'b1, 32'h1000_0004, 3'd2});
                check("rd_lit_aok1", data_addr_ok, 1'b0);
                at_neg(b + 3);
                check("rd_lit_ok", {data_data_ok, data_addr_ok, data_rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
            end
        join

        // Byte write at lane 3
        b = cyc;
        fork
            do_txn(1'b1, 2'd0, 32'h2000_0003, 32'hAA00_0000, 32'd0, 0, 0, 0, 1'b0);
            begin
                at_neg(b + 1);
                check("bw_lit", {axi.wstrb, axi.awsize, axi.wdata}, {4'b1000, 3'd0, 32'hAA00_0000});
                at_neg(b + 3);
                check("bw_lit_ok", data_data_ok, 1'b1);
            end
        join

        // AW delayed three cycles, W immediate
        b = cyc;
        fork
            do_txn(1'b1, 2'd2, 32'h3000_0010, 32'h0123_4567, 32'd0, 3, 0, 0, 1'b0);
            begin
                at_neg(b + 2);
                check("split_lit_mid", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
                at_neg(b + 4);
                check("split_lit_aw", {axi.awvalid, axi.bready}, 2'b10);
                at_neg(b + 5);
                check("split_lit_b", {axi.awvalid, axi.bready}, 2'b01);
            end
        join

        // Half write, upper half, W late and B late
        b = cyc;
        fork
            do_txn(1'b1, 2'd1, 32'h3000_0006, 32'h1234_0000, 32'd0, 0, 2, 2, 1'b0);
            begin
                at_neg(b + 1);
                check("half_lit", {axi.wstrb, axi.awsize}, {4'b1100, 3'd1});
            end
        join

        // size=3 write behaves as word
        b = cyc;
        fork
            do_txn(1'b1, 2'd3, 32'h3000_0008, 32'hCAFE_F00D, 32'd0, 1, 1, 0, 1'b0);
            begin
                at_neg(b + 1);
                check("sz3_lit", {axi.wstrb, axi.awsize}, {4'b1111, 3'd2});
            end
        join

        // R withheld ten cycles, stray requests while busy
        b = cyc;
        fork
            do_txn(1'b0, 2'd2, 32'h4000_0000, 32'd0, 32'h8765_4321, 0, 0, 10, 1'b1);
            begin
                at_neg(b + 7);
                check("bp_lit_mid", {axi.rready, data_addr_ok, data_data_ok}, 3'b100);
                at_neg(b + 12);
                check("bp_lit_pre", data_data_ok, 1'b0);
                at_neg(b + 13);
                check("bp_lit_ok", {data_data_ok, data_rdata}, {1'b1, 32'h8765_4321});
            end
        join

        // Back-to-back mix with assorted delays
        do_txn(1'b0, 2'd1, 32'h5000_0002, 32'd0, 32'hBEEF_0000, 2, 0, 1, 1'b0);
        do_txn(1'b1, 2'd0, 32'h5000_0001, 32'h0000_7700, 32'd0, 2, 2, 3, 1'b0);
        do_txn(1'b1, 2'd1, 32'h5000_0000, 32'h0000_ABCD, 32'd0, 0, 4, 0, 1'b0);
        do_txn(1'b0, 2'd0, 32'h5000_0003, 32'd0, 32'h1100_0000, 0, 0, 0, 1'b0);

        // Reset while waiting in RD_D
        b = cyc;
        fork
            do_txn(1'b0, 2'd2, 32'h6000_0000, 32'd0, 32'h0F0F_0F0F, 0, 0, 30, 1'b0);
            begin
                at_neg(b + 4);
                check("rst_pre_rready", axi.rready, 1'b1);
                #1;
                resetn   = 1'b0;
                s_active = 1'b0;
                m_rdata  = 32'd0;
                #1;
                check("rst_mid_lit", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, data_data_ok},
                      6'd0);
                check("rst_mid_rdata", data_rdata, 32'd0);
                at_neg(b + 6);
                #1;
                resetn = 1'b1;
                #1;
                check("rst_rel_aok", data_addr_ok, 1'b1);
            end
        join

        // Normal read after reset
        b = cyc;
        fork
            do_txn(1'b0, 2'd2, 32'h7000_0000, 32'd0, 32'h600D_CAFE, 0, 0, 0, 1'b0);
            begin
                at_neg(b + 3);
                check("post_rst_lit", {data_data_ok, data_rdata}, {1'b1, 32'h600D_CAFE});
            end
        join

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
